vfpu_engine: RTL and testbench
==============================

Name: vfpu_engine

Overview:
- Datapath stage that sits between the streamer's two source (load) streams and its sink (store) stream inside the HWPE.
- Joins operand streams A and B element-by-element and applies a 32-bit integer vector op selected by the control block.
- Pushes results into the sink stream through a 2-stage stallable pipeline.
- Reports busy/done back to the control FSM.

Parameters:
- DATA_WIDTH, 32, element width in bits; all arithmetic is done at this width.
- LEN_WIDTH, 16, width of the job length and element counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous active-high reset.
- clear_i  input  1  synchronous soft clear; same effect as reset.
- start_i  input  1  one-cycle pulse; accepted only in IDLE.
- op_i  input  3  operation select, sampled at start: 0 ADD, 1 SUB, 2 MUL (low half), 3 MIN signed, 4 MAX signed; 5-7 treated as ADD.
- len_i  input  LEN_WIDTH  number of elements, sampled at start.
- a_data_i  input  DATA_WIDTH  operand A data.
- a_valid_i  input  1  operand A valid.
- a_ready_o  output  1  operand A ready.
- b_data_i  input  DATA_WIDTH  operand B data.
- b_valid_i  input  1  operand B valid.
- b_ready_o  output  1  operand B ready.
- r_data_o  output  DATA_WIDTH  result data.
- r_valid_o  output  1  result valid.
- r_ready_i  input  1  result ready.
- r_last_o  output  1  high with the final result of the job.
- busy_o  output  1  high from start acceptance until done.
- done_o  output  1  one-cycle pulse when the job completes.
- cnt_o  output  LEN_WIDTH  number of results accepted downstream in the current job.

Behaviour:
- Reset/clear: FSM returns to IDLE; both pipeline valids, cnt_o and the internal input counter are zeroed; all outputs are 0.
- Data registers need not be reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE + start_i: latch op_i and len_i. If len_i == 0, go to DONE; otherwise go to RUN.
  - RUN: an input fires when a_valid_i & b_valid_i & s1_accept.
  - RUN: the input counter increments on each fire. When the fire that makes it equal len, go to DRAIN.
  - DRAIN: wait until both stages are empty and the last result has been accepted, then go to DONE.
  - DONE: done_o = 1 for exactly one cycle, then IDLE.
- start_i in any state other than IDLE is ignored.
- busy_o = (state != IDLE).
- Join rule:
  - a_ready_o = b_ready_o = (state == RUN) & s1_accept & a_valid_i & b_valid_i.
  - Neither stream is consumed without the other. Ready may depend on valid.
- Pipeline:
  - Stage 1 registers operands and op.
  - Stage 2 registers the result, which is driven on r_data_o with r_valid_o.
  - s2_accept = !s2_valid | r_ready_i.
  - s1_accept = !s1_valid | s2_accept.
  - With r_ready_i held high, the first result appears 2 cycles after the input fire; throughput is 1 element/cycle.
  - Backpressure: r_valid_o/r_data_o must stay stable while r_ready_i is low. No element may be lost or duplicated.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
  - MUL returns the low DATA_WIDTH bits of the signed product.
  - MIN/MAX use signed compare.
- r_last_o = r_valid_o & (result is the len-th element of the job).
- cnt_o increments on each r_valid_o & r_ready_i.
- No inputs are consumed in IDLE, DRAIN or DONE, even if valid is high.
- Reset or clear mid-job discards all in-flight elements. No done_o pulse is produced.

Optional Feature:
- Macro: VFPU_ENGINE_SAT_EN.
- Defined: ADD and SUB saturate to signed limits 0x7FFFFFFF / 0x80000000 (for DATA_WIDTH = 32) on overflow.
- Defined: a sticky output sat_o (1 bit) is added. It is set on any saturating result and cleared at start acceptance, reset and clear.
- Not defined: ADD/SUB wrap, and the sat_o port does not exist.

Test Plan:
- ADD, len=4, A={1,2,3,4}, B={10,20,30,40}, r_ready always 1 -> results {11,22,33,44}; first r_valid 2 cycles after first fire; r_last on 44; done_o pulse 1 cycle after final accept; cnt_o = 4.
- MIN, len=2, A={-5,7}, B={3,-9}, with B valid delayed 3 cycles -> no A consumption before B is valid; results {-5,-9}.
- MUL, len=3, r_ready toggling 1/0 every cycle -> results {A*B low bits} in order, stable while r_ready=0; no loss or duplicates; cnt_o = 3.
- start with len=0 -> busy_o high for 1 cycle, done_o pulse, no ready asserted, no r_valid.
- Reset asserted mid-job after 2 of 5 elements -> all outputs 0 immediately; a new ADD job of len=1 (5+6) then produces 11 with r_last.
- VFPU_ENGINE_SAT_EN: ADD 0x7FFFFFFF + 1 -> 0x7FFFFFFF, sat_o = 1. Without the macro -> 0x80000000.

Source files
------------

// File: rtl/vfpu_engine.sv
// vfpu_engine: joins operand streams A and B element-by-element and applies a
// 32-bit integer vector op (ADD/SUB/MUL/MIN/MAX). Results leave through a
// 2-stage stallable pipeline. Busy/done are reported to the control FSM.
// Optional: define VFPU_ENGINE_SAT_EN for saturating ADD/SUB and a sticky sat_o.
module vfpu_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic                  r_last_o,
    output logic                  busy_o,
    output logic                  done_o,
`ifdef VFPU_ENGINE_SAT_EN
    output logic                  sat_o,
`endif
    output logic [LEN_WIDTH-1:0]  cnt_o
);

    localparam int unsigned MSB = DATA_WIDTH - 1;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_MIN = 3'd3;
    localparam logic [2:0] OP_MAX = 3'd4;
`ifdef VFPU_ENGINE_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [2:0]            op_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  in_cnt;
    logic [LEN_WIDTH-1:0]  in_cnt_nxt;
    logic [LEN_WIDTH-1:0]  cnt;
    logic                  done_q;
    logic                  s1_valid, s1_last;
    logic [DATA_WIDTH-1:0] s1_a, s1_b;
    logic [2:0]            s1_op;
    logic                  s2_valid, s2_last;
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s1_accept, s2_accept, fire;
    logic [DATA_WIDTH-1:0] sum, diff, prod, alu_res;
`ifdef VFPU_ENGINE_SAT_EN
    logic                  sat_hit, sat_q;
`endif

    assign s2_accept  = !s2_valid | r_ready_i;
    assign s1_accept  = !s1_valid | s2_accept;
    assign fire       = (state == RUN) & s1_accept & a_valid_i & b_valid_i;
    assign in_cnt_nxt = LEN_WIDTH'(in_cnt + 1'b1);

    assign a_ready_o = fire;
    assign b_ready_o = fire;
    assign r_data_o  = s2_data;
    assign r_valid_o = s2_valid;
    assign r_last_o  = s2_valid & s2_last;
    assign busy_o    = (state != IDLE);
    assign done_o    = done_q;
    assign cnt_o     = cnt;
`ifdef VFPU_ENGINE_SAT_EN
    assign sat_o     = sat_q;
`endif

    // Stage-2 ALU; the low half of a product is identical for signed and unsigned operands.
    always_comb begin
        sum     = s1_a + s1_b;
        diff    = s1_a - s1_b;
        prod    = DATA_WIDTH'(s1_a * s1_b);
        alu_res = sum;
`ifdef VFPU_ENGINE_SAT_EN
        sat_hit = 1'b0;
`endif
        case (s1_op)
            OP_SUB: begin
                alu_res = diff;
`ifdef VFPU_ENGINE_SAT_EN
                if ((s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB])) begin
                    alu_res = s1_a[MSB] ? SAT_MIN : SAT_MAX;
                    sat_hit = 1'b1;
                end
`endif
            end
            OP_MUL: alu_res = prod;
            OP_MIN: alu_res = ($signed(s1_a) < $signed(s1_b)) ? s1_a : s1_b;
            OP_MAX: alu_res = ($signed(s1_a) < $signed(s1_b)) ? s1_b : s1_a;
            default: begin
                alu_res = sum;
`ifdef VFPU_ENGINE_SAT_EN
                if ((s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB])) begin
                    alu_res = s1_a[MSB] ? SAT_MIN : SAT_MAX;
                    sat_hit = 1'b1;
                end
`endif
            end
        endcase
    end

    // Stage-1 operand capture; payload needs no reset since s1_valid qualifies it.
    always_ff @(posedge clk_i) begin
        if (fire) begin
            s1_a  <= a_data_i;
            s1_b  <= b_data_i;
            s1_op <= op_q;
        end
    end

    // Control FSM, pipeline valids, counters and registered status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            len_q    <= '0;
            in_cnt   <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
`ifdef VFPU_ENGINE_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else if (clear_i) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            len_q    <= '0;
            in_cnt   <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
`ifdef VFPU_ENGINE_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (s1_accept) begin
                s1_valid <= fire;
                if (fire) s1_last <= (in_cnt_nxt == len_q);
            end
            if (s2_accept) begin
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                if (s1_valid) s2_data <= alu_res;
`ifdef VFPU_ENGINE_SAT_EN
                if (s1_valid && sat_hit) sat_q <= 1'b1;
`endif
            end
            if (s2_valid && r_ready_i) cnt <= LEN_WIDTH'(cnt + 1'b1);
            case (state)
                IDLE: if (start_i) begin
                    op_q   <= op_i;
                    len_q  <= len_i;
                    in_cnt <= '0;
                    cnt    <= '0;
`ifdef VFPU_ENGINE_SAT_EN
                    sat_q  <= 1'b0;
`endif
                    if (len_i == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state  <= RUN;
                    end
                end
                RUN: if (fire) begin
                    in_cnt <= in_cnt_nxt;
                    if (in_cnt_nxt == len_q) state <= DRAIN;
                end
                DRAIN: if (s2_valid && s2_last && r_ready_i) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vfpu_engine.sv
// tb_vfpu_engine: randomized self-checking bench for vfpu_engine against a
// plain-arithmetic reference of the vector ops.
module tb_vfpu_engine;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i, clear_i, start_i;
    logic [2:0]    op_i;
    logic [LW-1:0] len_i;
    logic [DW-1:0] a_data_i, b_data_i;
    logic          a_valid_i, b_valid_i, r_ready_i;
    logic          a_ready_o, b_ready_o, r_valid_o, r_last_o, busy_o, done_o;
    logic [DW-1:0] r_data_o;
    logic [LW-1:0] cnt_o;
`ifdef VFPU_ENGINE_SAT_EN
    logic          sat_o;
`endif

    vfpu_engine #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .op_i(op_i), .len_i(len_i),
        .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .b_data_i(b_data_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .r_last_o(r_last_o), .busy_o(busy_o), .done_o(done_o),
`ifdef VFPU_ENGINE_SAT_EN
        .sat_o(sat_o),
`endif
        .cnt_o(cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Job stimulus and observations
    logic [DW-1:0] va[$], vb[$], got_d[$];
    bit            got_l[$];
    int fires, first_fire, first_rv, done_cyc, done_cnt, busy_cyc;
    int stall_bad, ready_wo_b, ready_seen, ready_mismatch, last_acc;
    bit timeout;

    // Reference result of one element from the op rules, using wide signed arithmetic.
    function automatic logic [DW-1:0] ref_res(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: r = sa - sb;
            3'd2: r = sa * sb;
            3'd3: r = (sa < sb) ? sa : sb;
            3'd4: r = (sa > sb) ? sa : sb;
            default: r = sa + sb;
        endcase
`ifdef VFPU_ENGINE_SAT_EN
        if (op != 3'd2 && op != 3'd3 && op != 3'd4) begin
            if (r > 64'sd2147483647)  r = 64'sd2147483647;
            if (r < -64'sd2147483648) r = -64'sd2147483648;
        end
`endif
        return 32'(r);
    endfunction

    // Drive one job cycle by cycle; inputs change after each falling edge, observe 1ns later.
    // rmode: 0 ready always, 1 ready toggling, 2 ready random.
    task automatic run_job(input logic [2:0] op, input int len, input int b_delay, input int rmode,
                           input bit rnd_valid, input bit rnd_start, input int abort_after);
        int c, idx, post;
        bit prev_stall, done_seen;
        logic [DW-1:0] prev_d;
        got_d.delete(); got_l.delete();
        fires = 0; first_fire = -1; first_rv = -1; done_cyc = -1; done_cnt = 0; busy_cyc = 0;
        stall_bad = 0; ready_wo_b = 0; ready_seen = 0; ready_mismatch = 0; last_acc = -1;
        timeout = 0; c = 0; idx = 0; post = 0; prev_stall = 0; done_seen = 0; prev_d = '0;
        while (1) begin
            @(negedge clk_i);
            start_i   = (c == 0) || (rnd_start && !done_seen && ($urandom_range(0, 3) == 0));
            op_i      = (c == 0) ? op : 3'($urandom);
            len_i     = (c == 0) ? LW'(len) : LW'($urandom);
            a_valid_i = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            b_valid_i = (c >= b_delay) && (rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1);
            a_data_i  = (idx < va.size()) ? va[idx] : DW'($urandom);
            b_data_i  = (idx < vb.size()) ? vb[idx] : DW'($urandom);
            r_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (a_ready_o && !b_valid_i) ready_wo_b++;
            if (a_ready_o != b_ready_o) ready_mismatch++;
            if (a_ready_o || b_ready_o) ready_seen++;
            if (a_ready_o && a_valid_i && b_valid_i) begin
                fires++;
                idx++;
                if (first_fire < 0) first_fire = c;
            end
            if (prev_stall && (!r_valid_o || r_data_o !== prev_d)) stall_bad++;
            if (r_valid_o && first_rv < 0) first_rv = c;
            if (r_valid_o && r_ready_i) begin
                got_d.push_back(r_data_o);
                got_l.push_back(r_last_o);
                last_acc = c;
            end
            prev_stall = r_valid_o && !r_ready_i;
            prev_d     = r_data_o;
            if (busy_o) busy_cyc++;
            if (done_o) begin
                done_cnt++;
                done_cyc  = c;
                done_seen = 1'b1;
            end
            if (abort_after > 0 && fires == abort_after) break;
            if (done_seen) post++;
            if (post > 2) break;
            c++;
            if (c > 500) begin
                timeout = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (r_valid_o !== 1'b0) begin bad++; $display("FAIL reset_r_valid got=%b exp=0", r_valid_o); end
        total++; if (r_data_o !== '0) begin bad++; $display("FAIL reset_r_data got=%0h exp=0", r_data_o); end
        total++; if (r_last_o !== 1'b0) begin bad++; $display("FAIL reset_r_last got=%b exp=0", r_last_o); end
        total++; if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", a_ready_o, b_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
        total++; if (cnt_o !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
    endtask

    task automatic test_add();
        logic [DW-1:0] exp_d [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
        va = '{32'd1, 32'd2, 32'd3, 32'd4};
        vb = '{32'd10, 32'd20, 32'd30, 32'd40};
        run_job(3'd0, 4, 0, 0, 1'b0, 1'b0, 0);
        total++; if (timeout) begin bad++; $display("FAIL add_timeout got=1 exp=0"); end
        total++; if (got_d.size() != 4) begin bad++; $display("FAIL add_count got=%0d exp=4", got_d.size()); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== exp_d[i]) begin bad++; $display("FAIL add_data[%0d] got=%0d exp=%0d", i, got_d[i], exp_d[i]); end
            total++; if (got_l[i] !== (i == 3)) begin bad++; $display("FAIL add_last[%0d] got=%b exp=%b", i, got_l[i], i == 3); end
        end
        total++; if (first_rv != first_fire + 2) begin bad++; $display("FAIL add_latency got=%0d exp=%0d", first_rv, first_fire + 2); end
        total++; if (done_cyc != last_acc + 1) begin bad++; $display("FAIL add_done_cycle got=%0d exp=%0d", done_cyc, last_acc + 1); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL add_done_pulses got=%0d exp=1", done_cnt); end
        total++; if (cnt_o !== 16'd4) begin bad++; $display("FAIL add_cnt got=%0d exp=4", cnt_o); end
        total++; if (fires != 4) begin bad++; $display("FAIL add_fires got=%0d exp=4", fires); end
        total++; if (busy_cyc != done_cyc) begin bad++; $display("FAIL add_busy_cycles got=%0d exp=%0d", busy_cyc, done_cyc); end
    endtask

    task automatic test_min_join();
        va = '{-32'sd5, 32'sd7};
        vb = '{32'sd3, -32'sd9};
        run_job(3'd3, 2, 3, 0, 1'b0, 1'b0, 0);
        total++; if (timeout) begin bad++; $display("FAIL min_timeout got=1 exp=0"); end
        total++; if (ready_wo_b != 0) begin bad++; $display("FAIL min_ready_without_b got=%0d exp=0", ready_wo_b); end
        total++; if (first_fire < 3) begin bad++; $display("FAIL min_early_fire got=%0d exp>=3", first_fire); end
        total++; if (got_d.size() != 2) begin bad++; $display("FAIL min_count got=%0d exp=2", got_d.size()); end
        if (got_d.size() == 2) begin
            total++; if (got_d[0] !== 32'hFFFF_FFFB) begin bad++; $display("FAIL min_data0 got=%0h exp=fffffffb", got_d[0]); end
            total++; if (got_d[1] !== 32'hFFFF_FFF7) begin bad++; $display("FAIL min_data1 got=%0h exp=fffffff7", got_d[1]); end
        end
    endtask

    task automatic test_mul_backpressure();
        va.delete(); vb.delete();
        for (int i = 0; i < 3; i++) begin
            va.push_back(DW'($urandom));
            vb.push_back(DW'($urandom));
        end
        run_job(3'd2, 3, 0, 1, 1'b0, 1'b0, 0);
        total++; if (timeout) begin bad++; $display("FAIL mul_timeout got=1 exp=0"); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL mul_stable got=%0d exp=0", stall_bad); end
        total++; if (got_d.size() != 3) begin bad++; $display("FAIL mul_count got=%0d exp=3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== ref_res(3'd2, va[i], vb[i]) || got_l[i] !== (i == 2)) begin
                bad++;
                $display("FAIL mul_data[%0d] got=%0h/%b exp=%0h/%b", i, got_d[i], got_l[i], ref_res(3'd2, va[i], vb[i]), i == 2);
            end
        end
        total++; if (cnt_o !== 16'd3) begin bad++; $display("FAIL mul_cnt got=%0d exp=3", cnt_o); end
    endtask

    task automatic test_len_zero();
        va.delete(); vb.delete();
        run_job(3'd0, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (timeout) begin bad++; $display("FAIL len0_timeout got=1 exp=0"); end
        total++; if (busy_cyc != 1) begin bad++; $display("FAIL len0_busy_cycles got=%0d exp=1", busy_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL len0_done_pulses got=%0d exp=1", done_cnt); end
        total++; if (ready_seen != 0) begin bad++; $display("FAIL len0_ready got=%0d exp=0", ready_seen); end
        total++; if (first_rv != -1) begin bad++; $display("FAIL len0_r_valid got=%0d exp=-1", first_rv); end
    endtask

    task automatic test_reset_midjob();
        va = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        vb = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        run_job(3'd0, 5, 0, 0, 1'b0, 1'b0, 2);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if ({r_valid_o, r_last_o, a_ready_o, b_ready_o, busy_o, done_o} !== 6'b0 || cnt_o !== '0 || r_data_o !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b%b%b%b%b%b/%0d/%0h exp=000000/0/0",
                     r_valid_o, r_last_o, a_ready_o, b_ready_o, busy_o, done_o, cnt_o, r_data_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        va = '{32'd5};
        vb = '{32'd6};
        run_job(3'd0, 1, 0, 0, 1'b0, 1'b0, 0);
        total++; if (timeout) begin bad++; $display("FAIL postreset_timeout got=1 exp=0"); end
        total++;
        if (got_d.size() != 1 || got_d[0] !== 32'd11 || got_l[0] !== 1'b1) begin
            bad++;
            $display("FAIL postreset_result count=%0d got=%0h exp=1 result 11 with last", got_d.size(),
                     (got_d.size() > 0) ? got_d[0] : 32'hx);
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL postreset_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_clear_midjob();
        va = '{32'd9, 32'd8, 32'd7, 32'd6};
        vb = '{32'd1, 32'd1, 32'd1, 32'd1};
        run_job(3'd1, 4, 0, 1, 1'b0, 1'b0, 3);
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        total++;
        if ({r_valid_o, a_ready_o, busy_o, done_o} !== 4'b0 || cnt_o !== '0) begin
            bad++;
            $display("FAIL clear_outputs got=%b%b%b%b/%0d exp=0000/0", r_valid_o, a_ready_o, busy_o, done_o, cnt_o);
        end
    endtask

    task automatic test_sat();
        va = '{32'h7FFF_FFFF, 32'h8000_0000};
        vb = '{32'h0000_0001, 32'hFFFF_FFFF};
        run_job(3'd0, 2, 0, 0, 1'b0, 1'b0, 0);
        total++; if (got_d.size() != 2) begin bad++; $display("FAIL sat_count got=%0d exp=2", got_d.size()); end
        for (int i = 0; i < 2 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== ref_res(3'd0, va[i], vb[i])) begin bad++; $display("FAIL sat_data[%0d] got=%0h exp=%0h", i, got_d[i], ref_res(3'd0, va[i], vb[i])); end
        end
`ifdef VFPU_ENGINE_SAT_EN
        total++; if (got_d.size() > 0 && got_d[0] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_clamp got=%0h exp=7fffffff", got_d[0]); end
        total++; if (sat_o !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", sat_o); end
`else
        total++; if (got_d.size() > 0 && got_d[0] !== 32'h8000_0000) begin bad++; $display("FAIL wrap_add got=%0h exp=80000000", got_d[0]); end
`endif
        va = '{32'd1};
        vb = '{32'd1};
        run_job(3'd0, 1, 0, 0, 1'b0, 1'b0, 0);
`ifdef VFPU_ENGINE_SAT_EN
        total++; if (sat_o !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b exp=0", sat_o); end
`endif
        total++; if (got_d.size() != 1 || got_d[0] !== 32'd2) begin bad++; $display("FAIL sat_followup count=%0d exp=1 result 2", got_d.size()); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        int len;
        for (int j = 0; j < 20; j++) begin
            op  = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 8);
            va.delete(); vb.delete();
            for (int i = 0; i < len; i++) begin
                va.push_back(DW'($urandom));
                vb.push_back(($urandom_range(0, 3) == 0) ? va[i] : DW'($urandom));
            end
            run_job(op, len, $urandom_range(0, 2), 2, 1'b1, 1'b1, 0);
            total++; if (timeout) begin bad++; $display("FAIL rnd%0d_timeout got=1 exp=0", j); end
            total++; if (got_d.size() != len) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", j, got_d.size(), len); end
            for (int i = 0; i < len && i < got_d.size(); i++) begin
                total++;
                if (got_d[i] !== ref_res(op, va[i], vb[i]) || got_l[i] !== (i == len - 1)) begin
                    bad++;
                    $display("FAIL rnd%0d_op%0d[%0d] got=%0h/%b exp=%0h/%b", j, op, i, got_d[i], got_l[i],
                             ref_res(op, va[i], vb[i]), i == len - 1);
                end
            end
            total++; if (cnt_o !== LW'(len)) begin bad++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", j, cnt_o, len); end
            total++; if (done_cnt != 1 || stall_bad != 0 || ready_mismatch != 0) begin bad++; $display("FAIL rnd%0d_handshake done=%0d stall=%0d rdy=%0d exp=1/0/0", j, done_cnt, stall_bad, ready_mismatch); end
        end
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; op_i = '0; len_i = '0;
        a_data_i = '0; b_data_i = '0; a_valid_i = 1'b0; b_valid_i = 1'b0; r_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        test_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        test_add();
        test_min_join();
        test_mul_backpressure();
        test_len_zero();
        test_reset_midjob();
        test_clear_midjob();
        test_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
